// File: rtl/spi_bram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bram_arb
//  Function : Shares one single-port BRAM between uncontrollable SPI strobes
//             (absolute priority, fixed latency) and a req/ack host port.
//  Revision : 1.0  initial release
// ============================================================================
module spi_bram_arb #(
    parameter int         c_addr_bits = 32,
    parameter int         c_ram_bits  = 15,
    parameter logic [7:0] c_addr_ram  = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spi_rd,
    input  logic                   spi_wr,
    input  logic [c_addr_bits-1:0] spi_addr,
    input  logic [7:0]             spi_wdata,
    output logic [7:0]             spi_rdata,
    output logic                   spi_overrun,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [c_ram_bits-1:0]  host_addr,
    input  logic [7:0]             host_wdata,
    output logic [7:0]             host_rdata,
    output logic                   host_ack,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [c_ram_bits-1:0]  ram_addr,
    output logic [7:0]             ram_din,
    input  logic [7:0]             ram_dout
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SPI_ACC   = 3'd1,
        ST_SPI_DATA  = 3'd2,
        ST_HOST_ACC  = 3'd3,
        ST_HOST_DATA = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  spi_rd_q, spi_wr_q;
    logic                  spi_pend_q, spi_pend_d;
    logic                  spi_we_q, spi_we_d;
    logic [c_ram_bits-1:0] spi_addr_q, spi_addr_d;
    logic [7:0]            spi_wdata_q, spi_wdata_d;
    logic                  spi_overrun_q, spi_overrun_d;
    logic [7:0]            spi_rdata_q, spi_rdata_d;
    logic [7:0]            host_rdata_q, host_rdata_d;
    logic                  host_ack_q, host_ack_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [c_ram_bits-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_din_q, ram_din_d;
    logic                  op_we_q, op_we_d;

    logic w_rd_rise, w_wr_rise, w_in_win, w_spi_req;

    assign w_rd_rise = spi_rd & ~spi_rd_q;
    assign w_wr_rise = spi_wr & ~spi_wr_q;
    assign w_in_win  = (spi_addr[c_addr_bits-1 -: 8] == c_addr_ram);
    assign w_spi_req = (w_rd_rise | w_wr_rise) & w_in_win;

    // Address bits between the BRAM range and the window byte are don't-care.
    generate
        if (c_addr_bits - 8 > c_ram_bits) begin : g_addr_gap
            logic w_unused_mid;
            assign w_unused_mid = ^spi_addr[c_addr_bits-9:c_ram_bits];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        spi_pend_d    = spi_pend_q;
        spi_we_d      = spi_we_q;
        spi_addr_d    = spi_addr_q;
        spi_wdata_d   = spi_wdata_q;
        spi_overrun_d = spi_overrun_q;
        spi_rdata_d   = spi_rdata_q;
        host_rdata_d  = host_rdata_q;
        host_ack_d    = 1'b0;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_din_d     = ram_din_q;
        op_we_d       = op_we_q;

        case (state_q)
            ST_IDLE: begin
                if (spi_pend_q) begin
                    state_d    = ST_SPI_ACC;
                    spi_pend_d = 1'b0;
                    ram_en_d   = 1'b1;
                    ram_we_d   = spi_we_q;
                    ram_addr_d = spi_addr_q;
                    ram_din_d  = spi_wdata_q;
                    op_we_d    = spi_we_q;
                end else if (host_req && !host_ack_q) begin
                    state_d    = ST_HOST_ACC;
                    ram_en_d   = 1'b1;
                    ram_we_d   = host_we;
                    ram_addr_d = host_addr;
                    ram_din_d  = host_wdata;
                    op_we_d    = host_we;
                end
            end
            ST_SPI_ACC:  state_d = ST_SPI_DATA;
            ST_SPI_DATA: begin
                if (!op_we_q) spi_rdata_d = ram_dout;
                state_d = ST_IDLE;
            end
            ST_HOST_ACC: state_d = ST_HOST_DATA;
            ST_HOST_DATA: begin
                if (!op_we_q) host_rdata_d = ram_dout;
                host_ack_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Capture after the FSM so a fresh strobe overrides the pending clear.
        if (w_spi_req) begin
            if (spi_pend_q) spi_overrun_d = 1'b1;
            spi_pend_d  = 1'b1;
            spi_we_d    = w_wr_rise;
            spi_addr_d  = spi_addr[c_ram_bits-1:0];
            spi_wdata_d = spi_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            spi_rd_q      <= 1'b0;
            spi_wr_q      <= 1'b0;
            spi_pend_q    <= 1'b0;
            spi_we_q      <= 1'b0;
            spi_addr_q    <= '0;
            spi_wdata_q   <= 8'h00;
            spi_overrun_q <= 1'b0;
            spi_rdata_q   <= 8'h00;
            host_rdata_q  <= 8'h00;
            host_ack_q    <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_din_q     <= 8'h00;
            op_we_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            spi_rd_q      <= spi_rd;
            spi_wr_q      <= spi_wr;
            spi_pend_q    <= spi_pend_d;
            spi_we_q      <= spi_we_d;
            spi_addr_q    <= spi_addr_d;
            spi_wdata_q   <= spi_wdata_d;
            spi_overrun_q <= spi_overrun_d;
            spi_rdata_q   <= spi_rdata_d;
            host_rdata_q  <= host_rdata_d;
            host_ack_q    <= host_ack_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_din_q     <= ram_din_d;
            op_we_q       <= op_we_d;
        end
    end

    assign spi_rdata   = spi_rdata_q;
    assign spi_overrun = spi_overrun_q;
    assign host_rdata  = host_rdata_q;
    assign host_ack    = host_ack_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_bram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_bram_arb
//  Function : Directed self-checking bench for spi_bram_arb with a BRAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_bram_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_rd, spi_wr;
    logic [31:0] spi_addr;
    logic [7:0]  spi_wdata, spi_rdata;
    logic        spi_overrun;
    logic        host_req, host_we;
    logic [14:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        host_ack;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'h00;

    logic [7:0]  mem [0:32767];
    int          total = 0;
    int          bad   = 0;
    int          en_cnt  = 0;
    int          ack_cnt = 0;
    int          snap_en, snap_ack;

    spi_bram_arb dut (
        .clk         (clk),
        .reset       (reset),
        .spi_rd      (spi_rd),
        .spi_wr      (spi_wr),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_rdata   (spi_rdata),
        .spi_overrun (spi_overrun),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_ack    (host_ack),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    always #5 clk = ~clk;

    // Read-first single-port BRAM, one cycle of read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (ram_en)   en_cnt  <= en_cnt + 1;
        if (host_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; spi_rd = 1'b0; spi_wr = 1'b0; spi_addr = 32'h0; spi_wdata = 8'h0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 15'h0; host_wdata = 8'h0;
        repeat (3) tick();
        chk("rst_spi_rdata", {24'h0, spi_rdata}, 32'h00);
        chk("rst_host_rdata", {24'h0, host_rdata}, 32'h00);
        chk("rst_host_ack", {31'h0, host_ack}, 32'h0);
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_ram_addr", {17'h0, ram_addr}, 32'h0);
        chk("rst_ram_din", {24'h0, ram_din}, 32'h0);
        chk("rst_overrun", {31'h0, spi_overrun}, 32'h0);
        reset = 1'b0;
        tick();

        // SPI write 0x5A to 0x123
        spi_addr = 32'h0000_0123; spi_wdata = 8'h5A; spi_wr = 1'b1;
        tick();
        chk("wr_no_en_t1", {31'h0, ram_en}, 32'h0);
        tick();
        chk("wr_en_t2", {31'h0, ram_en}, 32'h1);
        chk("wr_we_t2", {31'h0, ram_we}, 32'h1);
        chk("wr_addr_t2", {17'h0, ram_addr}, 32'h123);
        chk("wr_din_t2", {24'h0, ram_din}, 32'h5A);
        spi_wr = 1'b0;
        tick();
        chk("wr_en_off_t3", {31'h0, ram_en}, 32'h0);
        tick();

        // SPI read back 0x123
        spi_rd = 1'b1;
        tick();
        tick();
        chk("rd_en_t2", {31'h0, ram_en}, 32'h1);
        chk("rd_we_t2", {31'h0, ram_we}, 32'h0);
        chk("rd_addr_t2", {17'h0, ram_addr}, 32'h123);
        spi_rd = 1'b0;
        tick();
        chk("rd_data_t3_old", {24'h0, spi_rdata}, 32'h00);
        tick();
        chk("rd_data_t4", {24'h0, spi_rdata}, 32'h5A);
        tick();

        // SPI read outside the window is ignored
        snap_en = en_cnt;
        spi_addr = 32'hFB00_0000; spi_rd = 1'b1;
        repeat (6) tick();
        chk("oow_no_access", en_cnt, snap_en);
        chk("oow_rdata_kept", {24'h0, spi_rdata}, 32'h5A);
        spi_rd = 1'b0;
        tick();

        // Host write 0xC3 to 0x10
        host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0010; host_wdata = 8'hC3;
        tick();
        chk("hwr_en", {31'h0, ram_en}, 32'h1);
        chk("hwr_we", {31'h0, ram_we}, 32'h1);
        chk("hwr_addr", {17'h0, ram_addr}, 32'h10);
        chk("hwr_din", {24'h0, ram_din}, 32'hC3);
        tick();
        tick();
        chk("hwr_ack", {31'h0, host_ack}, 32'h1);
        host_req = 1'b0;
        tick();
        chk("hwr_ack_pulse", {31'h0, host_ack}, 32'h0);
        tick();

        // Host read of 0x10, req held through the ack cycle
        snap_en = en_cnt; snap_ack = ack_cnt;
        host_req = 1'b1; host_we = 1'b0;
        tick();
        chk("hrd_en", {31'h0, ram_en}, 32'h1);
        chk("hrd_we", {31'h0, ram_we}, 32'h0);
        tick();
        chk("hrd_ack_early", {31'h0, host_ack}, 32'h0);
        tick();
        chk("hrd_ack", {31'h0, host_ack}, 32'h1);
        chk("hrd_data", {24'h0, host_rdata}, 32'hC3);
        tick();
        chk("hrd_no_regrant", {31'h0, ram_en}, 32'h0);
        chk("hrd_ack_pulse", {31'h0, host_ack}, 32'h0);
        host_req = 1'b0;
        repeat (3) tick();
        chk("hrd_one_access", en_cnt, snap_en + 1);
        chk("hrd_one_ack", ack_cnt, snap_ack + 1);

        // SPI pending and host req both seen in IDLE: SPI goes first
        spi_addr = 32'h0000_0010; spi_rd = 1'b1;
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0123;
        tick();
        chk("prio_spi_first", {17'h0, ram_addr}, 32'h010);
        chk("prio_spi_en", {31'h0, ram_en}, 32'h1);
        spi_rd = 1'b0;
        tick();
        tick();
        chk("prio_spi_data", {24'h0, spi_rdata}, 32'hC3);
        chk("prio_host_wait", {31'h0, host_ack}, 32'h0);
        tick();
        chk("prio_host_addr", {17'h0, ram_addr}, 32'h123);
        tick();
        tick();
        chk("prio_host_ack", {31'h0, host_ack}, 32'h1);
        chk("prio_host_data", {24'h0, host_rdata}, 32'h5A);
        host_req = 1'b0;
        tick();

        // Worst case: SPI rise in the cycle the host is granted
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0010;
        spi_addr = 32'h0000_0123; spi_rd = 1'b1;
        tick();
        spi_rd = 1'b0;
        tick();
        tick();
        chk("wc_host_ack", {31'h0, host_ack}, 32'h1);
        chk("wc_host_data", {24'h0, host_rdata}, 32'hC3);
        host_req = 1'b0;
        tick();
        chk("wc_spi_en_t4", {31'h0, ram_en}, 32'h1);
        chk("wc_spi_addr_t4", {17'h0, ram_addr}, 32'h123);
        tick();
        chk("wc_spi_data_t5", {24'h0, spi_rdata}, 32'hC3);
        tick();
        chk("wc_spi_data_t6", {24'h0, spi_rdata}, 32'h5A);
        tick();

        // Overrun: second window rise while first still pending behind a host access
        snap_en = en_cnt;
        spi_addr = 32'h0000_0300; spi_wdata = 8'h11; spi_wr = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0010;
        tick();
        spi_wr = 1'b0;
        chk("ovr_clear_t1", {31'h0, spi_overrun}, 32'h0);
        tick();
        chk("ovr_clear_t2", {31'h0, spi_overrun}, 32'h0);
        spi_addr = 32'h0000_0301; spi_wdata = 8'h22; spi_wr = 1'b1;
        tick();
        chk("ovr_set", {31'h0, spi_overrun}, 32'h1);
        chk("ovr_host_ack", {31'h0, host_ack}, 32'h1);
        host_req = 1'b0;
        tick();
        chk("ovr_en", {31'h0, ram_en}, 32'h1);
        chk("ovr_we", {31'h0, ram_we}, 32'h1);
        chk("ovr_addr_second", {17'h0, ram_addr}, 32'h301);
        chk("ovr_din_second", {24'h0, ram_din}, 32'h22);
        spi_wr = 1'b0;
        repeat (4) tick();
        chk("ovr_access_cnt", en_cnt, snap_en + 2);
        chk("ovr_sticky", {31'h0, spi_overrun}, 32'h1);

        // rd and wr rise together: the write wins
        spi_addr = 32'h0000_0002; spi_wdata = 8'h77; spi_rd = 1'b1; spi_wr = 1'b1;
        tick();
        tick();
        chk("both_en", {31'h0, ram_en}, 32'h1);
        chk("both_we", {31'h0, ram_we}, 32'h1);
        chk("both_addr", {17'h0, ram_addr}, 32'h002);
        chk("both_din", {24'h0, ram_din}, 32'h77);
        spi_rd = 1'b0; spi_wr = 1'b0;
        tick();
        tick();
        chk("both_rdata_kept", {24'h0, spi_rdata}, 32'h5A);
        tick();

        // Reset during HOST_ACC
        snap_ack = ack_cnt;
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0123;
        tick();
        chk("rsta_en_acc", {31'h0, ram_en}, 32'h1);
        reset = 1'b1;
        tick();
        chk("rsta_en_off", {31'h0, ram_en}, 32'h0);
        chk("rsta_ack", {31'h0, host_ack}, 32'h0);
        chk("rsta_overrun", {31'h0, spi_overrun}, 32'h0);
        chk("rsta_spi_rdata", {24'h0, spi_rdata}, 32'h00);
        reset = 1'b0; host_req = 1'b0;
        repeat (3) tick();
        chk("rsta_no_ack", ack_cnt, snap_ack);
        chk("rsta_idle_en", {31'h0, ram_en}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
